idex_reg: RTL and testbench
===========================

IDEX_REG -- requirements
Module: idex_reg

Interface
REQ-001 Parameter DATA_WIDTH, default 32: register data, immediate and PC width.
REQ-002 Parameter RA_WIDTH, default 5: register address width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 id_valid  input  1  ID stage holds a valid decoded instruction.
REQ-006 id_pc / id_imm  input  DATA_WIDTH each  decoded PC / immediate.
REQ-007 id_rs1_data / id_rs2_data  input  DATA_WIDTH each  register file read data.
REQ-008 id_rs1_addr / id_rs2_addr / id_rd_addr  input  RA_WIDTH each  source/destination indices.
REQ-009 id_ctrl  input  ctrl_t  decoded control bundle (alu_op[3:0], alu_src, mem_read, mem_write, reg_write, mem_to_reg).
REQ-010 ex_stall  input  1  downstream hold request.
REQ-011 flush  input  1  EX branch redirect; kill ID/EX contents.
REQ-012 wb_we / wb_rd_addr / wb_rd_data  input  1 / RA_WIDTH / DATA_WIDTH  same-cycle writeback port.
REQ-013 IDEX_valid, IDEX_pc, IDEX_imm, IDEX_rs1_data, IDEX_rs2_data, IDEX_rs1_addr, IDEX_rs2_addr, IDEX_rd_addr, IDEX_ctrl  output  widths as matching id_* inputs  registered EX-stage operands; feed the forwarding unit.
REQ-014 id_stall  output  1  combinational; freezes PC and IF/ID.
REQ-015 bubble_cnt  output  16  count of load-use bubbles inserted.

Function
REQ-016 Per-edge priority SHALL be: reset > flush > ex_stall hold > load-use bubble > normal load.
REQ-017 Flush: IDEX_valid=0, IDEX_ctrl=0, IDEX_rd_addr=0 next cycle; flush wins over simultaneous ex_stall or hazard.
REQ-018 Hold (ex_stall=1, no flush): all IDEX_* keep value, except held rsN_data SHALL capture wb_rd_data when wb_we && wb_rd_addr!=0 && wb_rd_addr==IDEX_rsN_addr.
REQ-019 Load-use hazard = IDEX_valid && IDEX_ctrl.mem_read && IDEX_rd_addr!=0 && id_valid && (IDEX_rd_addr==id_rs1_addr || IDEX_rd_addr==id_rs2_addr).
REQ-020 On hazard (no flush/hold): register loads bubble (IDEX_valid=0, ctrl=0, rd_addr=0) for exactly one cycle; ID instruction loads the following cycle.
REQ-021 id_stall = ex_stall || (hazard && !flush).
REQ-022 Normal load: IDEX_* <= id_*, IDEX_valid <= id_valid; latency one cycle.
REQ-023 Write-through on load: if wb_we && wb_rd_addr!=0 && wb_rd_addr==id_rsN_addr, IDEX_rsN_data SHALL take wb_rd_data instead of id_rsN_data; register x0 never bypassed.
REQ-024 If id_valid=0 on normal load, IDEX_ctrl SHALL load as 0.
REQ-025 bubble_cnt increments by 1 per bubble inserted per REQ-020, saturating at 16'hFFFF.

Reset
REQ-026 When rst_n=0 at an edge: all IDEX_* outputs 0, IDEX_valid=0, bubble_cnt=0; reset mid-hold or mid-bubble discards state.
REQ-027 id_stall SHALL be 0 while rst_n=0.

Configuration
REQ-028 Macro IDEX_LOAD_USE_EN defined: REQ-019/020/025 active.
REQ-029 IDEX_LOAD_USE_EN undefined: no hazard logic; id_stall=ex_stall; bubble_cnt constant 0; all else unchanged.

Structure
REQ-030 Package pipe_pkg SHALL hold ctrl_t, ALU-op encodings and the x0 index constant.
REQ-031 Hazard detection SHALL be one sub-module, load_use_detect, instantiated only under IDEX_LOAD_USE_EN.

Verification
REQ-032 Load id_pc=32'h8000_0004, rs1_data=32'h11 -> next cycle IDEX_pc=32'h8000_0004, IDEX_rs1_data=32'h11, IDEX_valid=1.
REQ-033 IDEX holds lw x5 (mem_read=1, rd=5); ID presents add rs1=5 -> id_stall=1 one cycle, one bubble, bubble_cnt 0->1, add loads next cycle.
REQ-034 Same as REQ-033 with rd=0 -> no stall, bubble_cnt stays 0.
REQ-035 Load with id_rs2_addr=7, wb_we=1, wb_rd_addr=7, wb_rd_data=32'hDEAD -> IDEX_rs2_data=32'hDEAD.
REQ-036 ex_stall=1 three cycles with wb write x3=32'h42 while IDEX_rs1_addr=3 -> all else held, IDEX_rs1_data=32'h42.
REQ-037 flush=1 with ex_stall=1 and hazard present -> IDEX_valid=0, IDEX_ctrl=0 next cycle, bubble_cnt unchanged.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline types: decoded control bundle, ALU-op encodings, x0 index and
// the ID/EX register update selector.
package pipe_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_AND  = 4'h2,
    ALU_OR   = 4'h3,
    ALU_XOR  = 4'h4,
    ALU_SLL  = 4'h5,
    ALU_SRL  = 4'h6,
    ALU_SRA  = 4'h7,
    ALU_SLT  = 4'h8,
    ALU_SLTU = 4'h9,
    ALU_LUI  = 4'hA
  } alu_op_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    alu_src;
    logic    mem_read;
    logic    mem_write;
    logic    reg_write;
    logic    mem_to_reg;
  } ctrl_t;

  // Register x0 is hard-wired to zero and must never be forwarded.
  localparam int unsigned REG_X0 = 0;

  localparam int BUBBLE_CNT_W = 16;

  // One update action per clock edge, listed in priority order.
  typedef enum logic [2:0] {
    OP_RESET,
    OP_FLUSH,
    OP_HOLD,
    OP_BUBBLE,
    OP_LOAD
  } idex_op_e;

endpackage

// File: rtl/idex_reg_if.sv
// ID/EX boundary bundle: decoded ID inputs, writeback port, pipeline control
// and the registered EX-stage operands. slave = the register, master = its driver.
interface idex_reg_if
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int RA_WIDTH   = 5
);

  logic                    id_valid;
  logic [DATA_WIDTH-1:0]   id_pc;
  logic [DATA_WIDTH-1:0]   id_imm;
  logic [DATA_WIDTH-1:0]   id_rs1_data;
  logic [DATA_WIDTH-1:0]   id_rs2_data;
  logic [RA_WIDTH-1:0]     id_rs1_addr;
  logic [RA_WIDTH-1:0]     id_rs2_addr;
  logic [RA_WIDTH-1:0]     id_rd_addr;
  ctrl_t                   id_ctrl;

  logic                    ex_stall;
  logic                    flush;

  logic                    wb_we;
  logic [RA_WIDTH-1:0]     wb_rd_addr;
  logic [DATA_WIDTH-1:0]   wb_rd_data;

  logic                    IDEX_valid;
  logic [DATA_WIDTH-1:0]   IDEX_pc;
  logic [DATA_WIDTH-1:0]   IDEX_imm;
  logic [DATA_WIDTH-1:0]   IDEX_rs1_data;
  logic [DATA_WIDTH-1:0]   IDEX_rs2_data;
  logic [RA_WIDTH-1:0]     IDEX_rs1_addr;
  logic [RA_WIDTH-1:0]     IDEX_rs2_addr;
  logic [RA_WIDTH-1:0]     IDEX_rd_addr;
  ctrl_t                   IDEX_ctrl;

  logic                    id_stall;
  logic [BUBBLE_CNT_W-1:0] bubble_cnt;

  modport slave (
    input  id_valid, id_pc, id_imm, id_rs1_data, id_rs2_data,
           id_rs1_addr, id_rs2_addr, id_rd_addr, id_ctrl,
           ex_stall, flush, wb_we, wb_rd_addr, wb_rd_data,
    output IDEX_valid, IDEX_pc, IDEX_imm, IDEX_rs1_data, IDEX_rs2_data,
           IDEX_rs1_addr, IDEX_rs2_addr, IDEX_rd_addr, IDEX_ctrl,
           id_stall, bubble_cnt
  );

  modport master (
    output id_valid, id_pc, id_imm, id_rs1_data, id_rs2_data,
           id_rs1_addr, id_rs2_addr, id_rd_addr, id_ctrl,
           ex_stall, flush, wb_we, wb_rd_addr, wb_rd_data,
    input  IDEX_valid, IDEX_pc, IDEX_imm, IDEX_rs1_data, IDEX_rs2_data,
           IDEX_rs1_addr, IDEX_rs2_addr, IDEX_rd_addr, IDEX_ctrl,
           id_stall, bubble_cnt
  );

endinterface

// File: rtl/load_use_detect.sv
// Load-use hazard detector: a valid load in EX whose destination (not x0) is a
// source of the valid instruction in ID.
module load_use_detect
  import pipe_pkg::*;
#(
  parameter int RA_WIDTH = 5
) (
  input  logic                ex_valid,
  input  logic                ex_mem_read,
  input  logic [RA_WIDTH-1:0] ex_rd_addr,
  input  logic                id_valid,
  input  logic [RA_WIDTH-1:0] id_rs1_addr,
  input  logic [RA_WIDTH-1:0] id_rs2_addr,
  output logic                hazard
);

  logic src_match;

  assign src_match = (ex_rd_addr == id_rs1_addr) || (ex_rd_addr == id_rs2_addr);

  assign hazard = ex_valid && ex_mem_read && (ex_rd_addr != RA_WIDTH'(REG_X0))
               && id_valid && src_match;

endmodule

// File: rtl/idex_reg.sv
// ID/EX pipeline register with flush, hold, writeback write-through and
// optional load-use bubble insertion (enabled by macro IDEX_LOAD_USE_EN).
module idex_reg
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int RA_WIDTH   = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  idex_reg_if.slave   bus
);

  logic                  hazard;
  idex_op_e              op;
  logic [DATA_WIDTH-1:0] rs1_load, rs2_load;
  logic [DATA_WIDTH-1:0] rs1_hold, rs2_hold;
  logic                  wb_live;

`ifdef IDEX_LOAD_USE_EN
  load_use_detect #(
    .RA_WIDTH (RA_WIDTH)
  ) u_load_use_detect (
    .ex_valid    (bus.IDEX_valid),
    .ex_mem_read (bus.IDEX_ctrl.mem_read),
    .ex_rd_addr  (bus.IDEX_rd_addr),
    .id_valid    (bus.id_valid),
    .id_rs1_addr (bus.id_rs1_addr),
    .id_rs2_addr (bus.id_rs2_addr),
    .hazard      (hazard)
  );
`else
  assign hazard = 1'b0;
`endif

  // Held stall must not leak out while the pipeline is being reset.
  assign bus.id_stall = rst_n && (bus.ex_stall || (hazard && !bus.flush));

  // A writeback to x0 is architecturally a no-op, so it never bypasses.
  assign wb_live  = bus.wb_we && (bus.wb_rd_addr != RA_WIDTH'(REG_X0));

  assign rs1_load = (wb_live && bus.wb_rd_addr == bus.id_rs1_addr)   ? bus.wb_rd_data : bus.id_rs1_data;
  assign rs2_load = (wb_live && bus.wb_rd_addr == bus.id_rs2_addr)   ? bus.wb_rd_data : bus.id_rs2_data;
  assign rs1_hold = (wb_live && bus.wb_rd_addr == bus.IDEX_rs1_addr) ? bus.wb_rd_data : bus.IDEX_rs1_data;
  assign rs2_hold = (wb_live && bus.wb_rd_addr == bus.IDEX_rs2_addr) ? bus.wb_rd_data : bus.IDEX_rs2_data;

  // NOTE: always_comb assigns a default first so no path can infer a latch.
  always_comb begin
    op = OP_LOAD;
    if (!rst_n)            op = OP_RESET;
    else if (bus.flush)    op = OP_FLUSH;
    else if (bus.ex_stall) op = OP_HOLD;
    else if (hazard)       op = OP_BUBBLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    unique case (op)
      OP_RESET: begin
        bus.IDEX_valid    <= 1'b0;
        bus.IDEX_pc       <= '0;
        bus.IDEX_imm      <= '0;
        bus.IDEX_rs1_data <= '0;
        bus.IDEX_rs2_data <= '0;
        bus.IDEX_rs1_addr <= '0;
        bus.IDEX_rs2_addr <= '0;
        bus.IDEX_rd_addr  <= '0;
        bus.IDEX_ctrl     <= '0;
      end
      OP_FLUSH, OP_BUBBLE: begin
        bus.IDEX_valid    <= 1'b0;
        bus.IDEX_ctrl     <= '0;
        bus.IDEX_rd_addr  <= '0;
      end
      OP_HOLD: begin
        bus.IDEX_rs1_data <= rs1_hold;
        bus.IDEX_rs2_data <= rs2_hold;
      end
      OP_LOAD: begin
        bus.IDEX_valid    <= bus.id_valid;
        bus.IDEX_pc       <= bus.id_pc;
        bus.IDEX_imm      <= bus.id_imm;
        bus.IDEX_rs1_data <= rs1_load;
        bus.IDEX_rs2_data <= rs2_load;
        bus.IDEX_rs1_addr <= bus.id_rs1_addr;
        bus.IDEX_rs2_addr <= bus.id_rs2_addr;
        bus.IDEX_rd_addr  <= bus.id_rd_addr;
        bus.IDEX_ctrl     <= bus.id_valid ? bus.id_ctrl : '0;
      end
      default: ;
    endcase
  end

`ifdef IDEX_LOAD_USE_EN
  always_ff @(posedge clk) begin
    if (op == OP_RESET)
      bus.bubble_cnt <= '0;
    else if (op == OP_BUBBLE && bus.bubble_cnt != '1)
      bus.bubble_cnt <= bus.bubble_cnt + 1'b1;
  end
`else
  assign bus.bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_idex_reg.sv
// Directed bench for idex_reg: expected register states are queued as stimulus
// is driven and checked one cycle later; id_stall is checked before each edge.
module tb_idex_reg;
  import pipe_pkg::*;

`ifdef IDEX_LOAD_USE_EN
  localparam bit LU_EN = 1'b1;
`else
  localparam bit LU_EN = 1'b0;
`endif

  localparam ctrl_t C_NONE = '0;
  localparam ctrl_t C_ADD  = '{alu_op: ALU_ADD, alu_src: 1'b0, mem_read: 1'b0,
                               mem_write: 1'b0, reg_write: 1'b1, mem_to_reg: 1'b0};
  localparam ctrl_t C_LW   = '{alu_op: ALU_ADD, alu_src: 1'b1, mem_read: 1'b1,
                               mem_write: 1'b0, reg_write: 1'b1, mem_to_reg: 1'b1};
  localparam ctrl_t C_SUB  = '{alu_op: ALU_SUB, alu_src: 1'b0, mem_read: 1'b0,
                               mem_write: 1'b0, reg_write: 1'b1, mem_to_reg: 1'b0};

  typedef struct {
    string       tag;
    bit          full;
    logic        valid;
    logic [31:0] pc, imm, rs1d, rs2d;
    logic [4:0]  rs1a, rs2a, rd;
    ctrl_t       ctrl;
    logic [15:0] bcnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];
  logic [15:0] exp_bcnt = '0;

  always #5 clk = ~clk;

  idex_reg_if #(.DATA_WIDTH(32), .RA_WIDTH(5)) bus ();

  idex_reg #(.DATA_WIDTH(32), .RA_WIDTH(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input string tag, input bit full, input logic v,
                              input logic [31:0] pc, imm, r1d, r2d,
                              input logic [4:0] r1a, r2a, rd, input ctrl_t c);
    exp_t e;
    e.tag = tag; e.full = full; e.valid = v;
    e.pc = pc; e.imm = imm; e.rs1d = r1d; e.rs2d = r2d;
    e.rs1a = r1a; e.rs2a = r2a; e.rd = rd; e.ctrl = c; e.bcnt = exp_bcnt;
    return e;
  endfunction

  task automatic drive(input logic v, input logic [31:0] pc, imm, r1d, r2d,
                       input logic [4:0] r1a, r2a, rd, input ctrl_t c);
    bus.id_valid = v;   bus.id_pc = pc;         bus.id_imm = imm;
    bus.id_rs1_data = r1d; bus.id_rs2_data = r2d;
    bus.id_rs1_addr = r1a; bus.id_rs2_addr = r2a; bus.id_rd_addr = rd;
    bus.id_ctrl = c;
  endtask

  task automatic ctl(input logic stall, input logic fl, input logic we,
                     input logic [4:0] wa, input logic [31:0] wd);
    bus.ex_stall = stall; bus.flush = fl;
    bus.wb_we = we; bus.wb_rd_addr = wa; bus.wb_rd_data = wd;
  endtask

  task automatic stall_chk(input string tag, input logic exp);
    #1;
    check({tag, "_id_stall"}, 32'(bus.id_stall), 32'(exp));
  endtask

  // Advance one edge, then compare the DUT against the oldest queued expectation.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    check("sb_depth", 32'(sb.size()), 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check({e.tag, "_valid"}, 32'(bus.IDEX_valid), 32'(e.valid));
    check({e.tag, "_ctrl"},  32'(bus.IDEX_ctrl),  32'(e.ctrl));
    check({e.tag, "_rd"},    32'(bus.IDEX_rd_addr), 32'(e.rd));
    check({e.tag, "_bcnt"},  32'(bus.bubble_cnt), 32'(e.bcnt));
    if (e.full) begin
      check({e.tag, "_pc"},   bus.IDEX_pc,       e.pc);
      check({e.tag, "_imm"},  bus.IDEX_imm,      e.imm);
      check({e.tag, "_rs1d"}, bus.IDEX_rs1_data, e.rs1d);
      check({e.tag, "_rs2d"}, bus.IDEX_rs2_data, e.rs2d);
      check({e.tag, "_rs1a"}, 32'(bus.IDEX_rs1_addr), 32'(e.rs1a));
      check({e.tag, "_rs2a"}, 32'(bus.IDEX_rs2_addr), 32'(e.rs2a));
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    ctl(1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    drive(1'b1, 32'h1234, 32'h5, 32'h6, 32'h7, 5'd1, 5'd2, 5'd3, C_ADD);
    @(negedge clk);

    // Reset with stall requested: outputs clear, id_stall suppressed.
    stall_chk("reset", 1'b0);
    sb.push_back(mk("reset", 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, C_NONE));
    tick();

    // Basic load.
    rst_n = 1'b1;
    ctl(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    drive(1'b1, 32'h8000_0004, 32'h10, 32'h11, 32'h22, 5'd1, 5'd2, 5'd3, C_ADD);
    stall_chk("load", 1'b0);
    sb.push_back(mk("load", 1'b1, 1'b1, 32'h8000_0004, 32'h10, 32'h11, 32'h22, 5'd1, 5'd2, 5'd3, C_ADD));
    tick();

    // Write-through on rs2.
    ctl(1'b0, 1'b0, 1'b1, 5'd7, 32'hDEAD);
    drive(1'b1, 32'h8000_0008, 32'h0, 32'h55, 32'h1234, 5'd4, 5'd7, 5'd8, C_SUB);
    sb.push_back(mk("wt_rs2", 1'b1, 1'b1, 32'h8000_0008, 32'h0, 32'h55, 32'hDEAD, 5'd4, 5'd7, 5'd8, C_SUB));
    tick();

    // x0 never bypassed; invalid instruction loads with ctrl forced to zero.
    ctl(1'b0, 1'b0, 1'b1, 5'd0, 32'hBEEF);
    drive(1'b0, 32'h8000_000C, 32'h3, 32'h99, 32'h98, 5'd0, 5'd6, 5'd9, C_ADD);
    sb.push_back(mk("x0_inv", 1'b1, 1'b0, 32'h8000_000C, 32'h3, 32'h99, 32'h98, 5'd0, 5'd6, 5'd9, C_NONE));
    tick();

    // lw x5 enters EX.
    ctl(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    drive(1'b1, 32'h100, 32'h8, 32'h1000, 32'h0, 5'd2, 5'd6, 5'd5, C_LW);
    sb.push_back(mk("lw5", 1'b1, 1'b1, 32'h100, 32'h8, 32'h1000, 32'h0, 5'd2, 5'd6, 5'd5, C_LW));
    tick();

    // Dependent add: one bubble when hazard logic is built in.
    drive(1'b1, 32'h104, 32'h0, 32'hA1, 32'hA2, 5'd5, 5'd6, 5'd8, C_ADD);
    stall_chk("luse", LU_EN);
    if (LU_EN) begin
      exp_bcnt = exp_bcnt + 16'd1;
      sb.push_back(mk("bubble", 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, C_NONE));
    end else begin
      sb.push_back(mk("bubble", 1'b1, 1'b1, 32'h104, 32'h0, 32'hA1, 32'hA2, 5'd5, 5'd6, 5'd8, C_ADD));
    end
    tick();

    stall_chk("after_bubble", 1'b0);
    sb.push_back(mk("add_loads", 1'b1, 1'b1, 32'h104, 32'h0, 32'hA1, 32'hA2, 5'd5, 5'd6, 5'd8, C_ADD));
    tick();

    // lw x0 followed by a dependent-looking add: no stall.
    drive(1'b1, 32'h108, 32'h4, 32'h1, 32'h2, 5'd1, 5'd2, 5'd0, C_LW);
    sb.push_back(mk("lw0", 1'b1, 1'b1, 32'h108, 32'h4, 32'h1, 32'h2, 5'd1, 5'd2, 5'd0, C_LW));
    tick();
    drive(1'b1, 32'h10C, 32'h0, 32'h3, 32'h4, 5'd0, 5'd0, 5'd8, C_ADD);
    stall_chk("lw0_dep", 1'b0);
    sb.push_back(mk("lw0_dep", 1'b1, 1'b1, 32'h10C, 32'h0, 32'h3, 32'h4, 5'd0, 5'd0, 5'd8, C_ADD));
    tick();

    // Hold for three cycles with writeback to the held rs1.
    drive(1'b1, 32'h200, 32'h7, 32'h10, 32'h20, 5'd3, 5'd4, 5'd6, C_ADD);
    sb.push_back(mk("pre_hold", 1'b1, 1'b1, 32'h200, 32'h7, 32'h10, 32'h20, 5'd3, 5'd4, 5'd6, C_ADD));
    tick();
    ctl(1'b1, 1'b0, 1'b1, 5'd3, 32'h42);
    drive(1'b1, 32'h204, 32'hFF, 32'hEE, 32'hDD, 5'd9, 5'd10, 5'd11, C_SUB);
    stall_chk("hold1", 1'b1);
    sb.push_back(mk("hold1", 1'b1, 1'b1, 32'h200, 32'h7, 32'h42, 32'h20, 5'd3, 5'd4, 5'd6, C_ADD));
    tick();
    ctl(1'b1, 1'b0, 1'b1, 5'd9, 32'h77);
    stall_chk("hold2", 1'b1);
    sb.push_back(mk("hold2", 1'b1, 1'b1, 32'h200, 32'h7, 32'h42, 32'h20, 5'd3, 5'd4, 5'd6, C_ADD));
    tick();
    ctl(1'b1, 1'b0, 1'b0, 5'd4, 32'h66);
    sb.push_back(mk("hold3", 1'b1, 1'b1, 32'h200, 32'h7, 32'h42, 32'h20, 5'd3, 5'd4, 5'd6, C_ADD));
    tick();

    // Flush beats stall and hazard.
    ctl(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    drive(1'b1, 32'h300, 32'h0, 32'h5, 32'h6, 5'd1, 5'd2, 5'd5, C_LW);
    sb.push_back(mk("lw5b", 1'b1, 1'b1, 32'h300, 32'h0, 32'h5, 32'h6, 5'd1, 5'd2, 5'd5, C_LW));
    tick();
    ctl(1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
    drive(1'b1, 32'h304, 32'h0, 32'h7, 32'h8, 5'd5, 5'd2, 5'd9, C_ADD);
    stall_chk("flush_stall", 1'b1);
    sb.push_back(mk("flush_stall", 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, C_NONE));
    tick();

    // Flush alone masks a hazard's stall.
    ctl(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    drive(1'b1, 32'h308, 32'h0, 32'h5, 32'h6, 5'd1, 5'd2, 5'd5, C_LW);
    sb.push_back(mk("lw5c", 1'b1, 1'b1, 32'h308, 32'h0, 32'h5, 32'h6, 5'd1, 5'd2, 5'd5, C_LW));
    tick();
    ctl(1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
    drive(1'b1, 32'h30C, 32'h0, 32'h7, 32'h8, 5'd1, 5'd5, 5'd9, C_ADD);
    stall_chk("flush_haz", 1'b0);
    sb.push_back(mk("flush_haz", 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, C_NONE));
    tick();

    // Hold beats bubble: no bubble counted while EX is stalled.
    ctl(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    drive(1'b1, 32'h310, 32'h0, 32'h5, 32'h6, 5'd1, 5'd2, 5'd5, C_LW);
    sb.push_back(mk("lw5d", 1'b1, 1'b1, 32'h310, 32'h0, 32'h5, 32'h6, 5'd1, 5'd2, 5'd5, C_LW));
    tick();
    ctl(1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    drive(1'b1, 32'h314, 32'h0, 32'h7, 32'h8, 5'd5, 5'd2, 5'd9, C_ADD);
    stall_chk("hold_haz", 1'b1);
    sb.push_back(mk("hold_haz", 1'b1, 1'b1, 32'h310, 32'h0, 32'h5, 32'h6, 5'd1, 5'd2, 5'd5, C_LW));
    tick();

    // Reset mid-hold with hazard pending discards everything.
    rst_n = 1'b0;
    stall_chk("reset2", 1'b0);
    exp_bcnt = '0;
    sb.push_back(mk("reset2", 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, C_NONE));
    tick();

    rst_n = 1'b1;
    ctl(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    drive(1'b1, 32'h8000_0004, 32'h1, 32'h11, 32'h12, 5'd1, 5'd2, 5'd3, C_ADD);
    sb.push_back(mk("post_reset", 1'b1, 1'b1, 32'h8000_0004, 32'h1, 32'h11, 32'h12, 5'd1, 5'd2, 5'd3, C_ADD));
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
